reaction_ctrl: RTL

- Sequencing controller for the reaction timer: arms on start, waits a pseudo-random delay, lights the stimulus LED, and counts the user's response time in milliseconds (BCD).
- Detects early (cheat) and late (timeout) stops.
- Feeds the LED and the 4-digit BCD result to the existing seven-segment display multiplexer (an/sseg path); this block does not drive the display directly.

---
 rtl/reaction_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/reaction_ctrl.sv
`default_nettype none
// ==========================================================================
// reaction_ctrl : reaction-timer sequencer (arm, random wait, BCD ms count)
// Revision 1.0
// ==========================================================================
module reaction_ctrl #(
  parameter int CLK_PER_MS  = 100000,
  parameter int MIN_WAIT_MS = 2000,
  parameter int RAND_BITS   = 10
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic        stop,
  output logic        led,
  output logic [15:0] result_bcd,
  output logic        show_hi,
  output logic        busy
);

  localparam int MS_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS));

  localparam logic [MS_W-1:0]   C_MS_LAST  = MS_W'(CLK_PER_MS - 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MIN = WAIT_W'(MIN_WAIT_MS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_TIME    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_CHEAT   = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [15:0]       r_lfsr;
  logic [MS_W-1:0]   r_ms_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [15:0]       r_result;
  logic [15:0]       w_next_result;
  logic              r_led;
  logic              r_show_hi;
  logic              r_busy;
  logic              w_timing;
  logic              w_tick;
  logic              w_load;

  // Ripple a +1 through four BCD digits.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_timing = (r_state == S_WAIT) || (r_state == S_TIME);
  assign w_tick   = w_timing && (r_ms_cnt == C_MS_LAST);

  always_comb begin
    w_next_state  = r_state;
    w_next_result = r_result;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_CHEAT, S_TIMEOUT: begin
        if (start) begin
          w_next_state  = S_WAIT;
          w_next_result = 16'h0000;
          w_load        = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop) begin
          w_next_state  = S_CHEAT;
          w_next_result = 16'h9999;
        end else if (w_tick && (r_wait_cnt == WAIT_W'(1))) begin
          w_next_state  = S_TIME;
          w_next_result = 16'h0000;
        end
      end
      S_TIME: begin
        // A stop in the same cycle as a tick freezes the value un-incremented.
        if (stop) begin
          w_next_state = S_DONE;
        end else if (w_tick) begin
          w_next_result = bcd_inc(r_result);
          if (r_result == 16'h0999) begin
            w_next_state = S_TIMEOUT;
          end
        end
      end
      default: begin
        w_next_state  = S_IDLE;
        w_next_result = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_lfsr     <= 16'hACE1;
      r_ms_cnt   <= '0;
      r_wait_cnt <= '0;
      r_result   <= 16'h0000;
      r_led      <= 1'b0;
      r_show_hi  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_lfsr   <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_state  <= w_next_state;
      r_result <= w_next_result;

      // Restart the ms prescaler on every state change.
      if (w_timing && (w_next_state == r_state)) begin
        r_ms_cnt <= w_tick ? '0 : r_ms_cnt + MS_W'(1);
      end else begin
        r_ms_cnt <= '0;
      end

      if (w_load) begin
        r_wait_cnt <= C_WAIT_MIN + WAIT_W'(r_lfsr[RAND_BITS-1:0]);
      end else if ((r_state == S_WAIT) && w_tick && !stop) begin
        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
      end

      r_led     <= (w_next_state == S_TIME);
      r_busy    <= (w_next_state == S_WAIT) || (w_next_state == S_TIME);
      r_show_hi <= (w_next_state == S_IDLE);
    end
  end

  assign led        = r_led;
  assign result_bcd = r_result;
  assign show_hi    = r_show_hi;
  assign busy       = r_busy;

endmodule
`default_nettype wire
